// File: rtl/present_ctr_mode_if.sv
// Data-path handshake bundle for present_ctr_mode: input blocks (din) and
// result blocks (dout), each a valid/ready pair.
interface present_ctr_mode_if;
    logic [63:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready;

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid
    );
endinterface

// File: rtl/present_ctr_mode.sv
// PRESENT counter-mode wrapper: drives an external PRESENT core with
// iv+counter blocks and XORs each keystream block into the data stream.
module present_ctr_mode #(
    parameter int unsigned CTR_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [63:0]       iv,
    present_ctr_mode_if.slave bus,
    output logic              busy,
    input  logic              core_key_ready,
    output logic [63:0]       core_block_i,
    output logic              core_enc_dec,
    output logic              core_rq,
    input  logic [63:0]       core_block_o,
    input  logic              core_done
);

    typedef enum logic [2:0] {IDLE, KEYWAIT, REQ, CALC, READY} state_t;

    // Counter field mask; the add below cannot carry into the fixed iv bits.
    localparam logic [63:0] CTR_MASK = (64'(1) << CTR_WIDTH) - 64'(1);

    state_t               state;
    state_t               state_next;
    logic [63:0]          iv_reg;
    logic [CTR_WIDTH-1:0] ctr;
    logic [63:0]          ks_reg;
    logic [63:0]          dout_reg;
    logic                 out_valid;
    logic                 calc_armed;
    logic                 ready_int;
    logic                 din_fire;
    logic                 ks_load;
    logic                 ks_drop;

    // Combinational from registers that only change in READY or on start,
    // so it stays stable for the whole REQ..CALC window.
    assign core_block_i = (iv_reg & ~CTR_MASK) | ((iv_reg + 64'(ctr)) & CTR_MASK);
    assign core_enc_dec = 1'b0;
    assign busy         = (state != IDLE);
    assign din_fire     = ready_int & bus.din_valid;
    assign ks_drop      = ((state == CALC) || (state == READY)) && !core_key_ready;

    assign bus.din_ready  = ready_int;
    assign bus.dout       = dout_reg;
    assign bus.dout_valid = out_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready_int  = 1'b0;
        core_rq    = 1'b0;
        ks_load    = 1'b0;
        case (state)
            IDLE: ;
            KEYWAIT: if (core_key_ready) state_next = REQ;
            REQ: begin
                core_rq    = 1'b1;
                state_next = CALC;
            end
            CALC: begin
                // calc_armed is low on the first CALC cycle: done may still be
                // high from the previous request there.
                if (!core_key_ready) begin
                    state_next = KEYWAIT;
                end else if (calc_armed && core_done) begin
                    ks_load    = 1'b1;
                    state_next = READY;
                end
            end
            READY: begin
                ready_int = !start && (!out_valid || bus.dout_ready);
                if (!core_key_ready)                 state_next = KEYWAIT;
                else if (ready_int && bus.din_valid) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
        if (start) state_next = KEYWAIT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iv_reg     <= '0;
            ctr        <= '0;
            ks_reg     <= '0;
            dout_reg   <= '0;
            out_valid  <= 1'b0;
            calc_armed <= 1'b0;
        end else begin
            calc_armed <= (state == CALC);
            if (start) begin
                iv_reg    <= iv;
                ctr       <= '0;
                ks_reg    <= '0;
                out_valid <= 1'b0;
            end else begin
                if (ks_load)      ks_reg <= core_block_o;
                else if (ks_drop) ks_reg <= '0;
                if (din_fire) begin
                    dout_reg  <= bus.din ^ ks_reg;
                    out_valid <= 1'b1;
                    ctr       <= ctr + CTR_WIDTH'(1);
                end else if (out_valid && bus.dout_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/present_ctr_mode.md
PRESENT_CTR_MODE -- requirements
Module: present_ctr_mode

Interface
REQ-001 Parameter CTR_WIDTH, default 32: width of the counter field, which occupies the low bits of the counter block.
REQ-002 The block SHALL use reset rst (synchronous, active-high) and clock clk.
REQ-003 Port clk  input  1  clock; all logic SHALL be rising-edge.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port start  input  1  single-cycle pulse that loads iv, clears the counter and begins keystream prefetch.
REQ-006 Port iv  input  64  nonce/IV; sampled only when start=1.
REQ-007 Port din, din_valid, din_ready  input 64 / input 1 / output 1  plaintext-or-ciphertext input handshake; transfer occurs when valid&ready.
REQ-008 Port dout, dout_valid, dout_ready  output 64 / output 1 / input 1  result output handshake; transfer occurs when valid&ready.
REQ-009 Port busy  output 1  high in every state except IDLE.
REQ-010 Port core_key_ready  input 1  cipher core key-expansion complete.
REQ-011 Port core_block_i, core_enc_dec, core_rq  output 64 / output 1 / output 1  cipher core input block, mode (tied 0 = encrypt), request pulse.
REQ-012 Port core_block_o, core_done  input 64 / input 1  cipher core result; done is held high until the next core_rq.

Function
REQ-013 The block SHALL implement PRESENT-CTR: dout = din XOR E(ctr_block), identical for encryption and decryption.
REQ-014 ctr_block = {iv_reg[63:CTR_WIDTH], iv_reg[CTR_WIDTH-1:0] + ctr} with the addition modulo 2^CTR_WIDTH and no carry into the upper bits.
REQ-015 FSM states: IDLE, KEYWAIT, REQ, CALC, READY.
REQ-016 IDLE -> KEYWAIT on start; KEYWAIT -> REQ when core_key_ready=1.
REQ-017 In REQ, core_rq=1 for exactly one cycle, core_block_i=ctr_block, then -> CALC.
REQ-018 core_block_i SHALL remain stable from REQ until core_done is sampled in CALC.
REQ-019 CALC SHALL ignore core_done in its first cycle (stale-done guard); afterwards, when core_done=1, it latches ks_reg<=core_block_o and -> READY.
REQ-020 din_ready = 1 only in READY, with start=0, and with (dout_valid=0 or dout_ready=1).
REQ-021 On a din handshake: dout<=din^ks_reg, dout_valid<=1, ctr<=ctr+1, and the FSM -> REQ (next-keystream prefetch).
REQ-022 dout_valid SHALL clear on a dout handshake unless a new result is loaded in the same cycle, in which case it stays 1 with the new data.
REQ-023 dout SHALL hold its value while dout_valid=1 and dout_ready=0.
REQ-024 Counter wrap: after ctr = 2^CTR_WIDTH-1 the next value SHALL be 0; operation continues without error.
REQ-025 A start in any non-IDLE state SHALL abort the current operation: reload iv, ctr<=0, invalidate ks_reg, clear dout_valid, go to KEYWAIT. The pending core result is discarded.
REQ-026 start has priority over a simultaneous din handshake; din is not accepted in that cycle.
REQ-027 core_key_ready dropping in CALC or READY SHALL send the FSM to KEYWAIT and invalidate ks_reg. The current ctr is kept and recomputed.
REQ-028 Throughput: one block per (core latency + 3) cycles; latency from din handshake to dout_valid is 1 cycle.

Reset
REQ-029 On rst: state IDLE, ctr=0, iv_reg=0, ks_reg=0, dout=0, dout_valid=0, din_ready=0, busy=0, core_rq=0, core_block_i=0, core_enc_dec=0.
REQ-030 rst SHALL take priority over start and all handshakes in the same cycle.

Verification
REQ-031 Key 0, iv=0, start; din=0 -> dout=5579C1387B228445, core_block_i=0 on the first request.
REQ-032 Same key; second din=0 -> core_block_i=0000000000000001 on the next request; dout=E(1).
REQ-033 iv=00000000FFFFFFFF, CTR_WIDTH=32; two blocks -> core_block_i sequence FFFFFFFF then 00000000, upper 32 bits unchanged (wrap).
REQ-034 dout_ready=0 for 100 cycles with 2 blocks offered -> second block not accepted, dout stable, no data lost after release.
REQ-035 start asserted during CALC with iv=1234 -> stale core result not output; next core_block_i=0000000000001234.
REQ-036 rst mid-CALC -> all outputs at reset values next cycle; busy=0.
